// File: rtl/decim_pkg.sv
// decim_pkg: shared state encodings, stage IDs and default sizes for the decimator MAC scheduler
//   STG_*        stage indices (FIR, HB1, HB2) shared with the filter stages
//   *_DEF        default N_REQ / TAP_W / MAC_LAT
//   sel_w()      width of a stage index, never below 1
package decim_pkg;
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_RUN, S_DRAIN, S_DONE} state_e;
  localparam int STG_FIR = 0;
  localparam int STG_HB1 = 1;
  localparam int STG_HB2 = 2;
  localparam int N_REQ_DEF = 3;
  localparam int TAP_W_DEF = 5;
  localparam int MAC_LAT_DEF = 2;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/decim_sched_arb.sv
// decim_sched_arb: combinational one-hot winner selection among pending stage requests
//   clk, rst_n   clock / async active-low reset (round-robin build only)
//   adv_i        a grant is taken this cycle; pointer moves past the winner (round-robin only)
//   pend_i       pending request per stage
//   win_oh_o     one-hot winner, zero when nothing pends
//   win_idx_o    index of the winner
// Build option DECIM_SCHED_RR_EN: round-robin from an internal pointer; otherwise lowest index wins.
module decim_sched_arb import decim_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = sel_w(N_REQ)
) (
`ifdef DECIM_SCHED_RR_EN
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
`endif
  input  logic [N_REQ-1:0] pend_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [SEL_W-1:0] win_idx_o
);
  logic [SEL_W-1:0] start;
`ifdef DECIM_SCHED_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  assign ptr_d = adv_i ? (int'(win_idx_o) == N_REQ - 1 ? '0 : win_idx_o + 1'b1) : ptr_q;
  assign start = ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
`else
  assign start = '0;
`endif
  // Scan backwards so the last hit written is the first pending stage at or after start.
  always_comb begin
    win_oh_o = '0;
    win_idx_o = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (pend_i[(int'(start) + k) % N_REQ]) begin
        win_oh_o = '0;
        win_oh_o[(int'(start) + k) % N_REQ] = 1'b1;
        win_idx_o = SEL_W'((int'(start) + k) % N_REQ);
      end
  end
endmodule

// File: rtl/decim_mac_scheduler.sv
// decim_mac_scheduler: shares one MAC between the post-CIC stages, sequencing clear/enable/tap index
//   clk, rst_n       clock / async active-low reset (aborts any job, no done)
//   req_i            one-cycle job request per stage
//   req_taps_i       tap count per stage, slice i = [i*TAP_W +: TAP_W], sampled at grant
//   ovr_clr_i        clears overrun flags (a same-cycle new overrun wins)
//   mac_clr_o        accumulator clear, GRANT cycle
//   mac_en_o         accumulate enable, RUN cycles
//   mac_tap_idx_o    tap index 0..taps-1 during RUN, else 0
//   mac_sel_o        owning stage, 0 when idle
//   done_o           one-cycle pulse for the finished stage
//   busy_o           a job is in flight
//   overrun_o        sticky per-stage lost-request flag
// Build option DECIM_SCHED_RR_EN selects round-robin arbitration (fixed priority otherwise).
module decim_mac_scheduler import decim_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int TAP_W = TAP_W_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF,
  localparam int SEL_W = sel_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*TAP_W-1:0] req_taps_i,
  input  logic                   ovr_clr_i,
  output logic                   mac_clr_o,
  output logic                   mac_en_o,
  output logic [TAP_W-1:0]       mac_tap_idx_o,
  output logic [SEL_W-1:0]       mac_sel_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic [N_REQ-1:0]       overrun_o
);
  localparam int LAT_W = MAC_LAT > 1 ? $clog2(MAC_LAT) : 1;
  localparam int CNT_W = TAP_W > LAT_W ? TAP_W : LAT_W;
  state_e state_q, state_d, post_run;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAP_W-1:0] taps_q, taps_d, idx_q;
  logic [SEL_W-1:0] sel_q, sel_d, win_idx;
  logic [N_REQ-1:0] pend_q, pend_d, ovr_q, ovr_d, done_q, own, conflict, win_oh;
  logic clr_q, en_q, busy_q, grant, last_tap, last_lat;
  decim_sched_arb #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_arb (
`ifdef DECIM_SCHED_RR_EN
    .clk(clk),
    .rst_n(rst_n),
    .adv_i(grant),
`endif
    .pend_i(pend_q),
    .win_oh_o(win_oh),
    .win_idx_o(win_idx)
  );
  // A stage owns the MAC from GRANT through DONE; its winning IDLE cycle is covered by pend_q.
  assign own = state_q != S_IDLE ? N_REQ'(1) << sel_q : '0;
  assign conflict = pend_q | own;
  assign grant = state_q == S_IDLE && |pend_q;
  assign pend_d = (pend_q & ~(grant ? win_oh : '0)) | (req_i & ~conflict);
  assign ovr_d = (ovr_clr_i ? '0 : ovr_q) | (req_i & conflict);
  assign post_run = MAC_LAT > 0 ? S_DRAIN : S_DONE;
  assign last_tap = cnt_q == CNT_W'(taps_q) - CNT_W'(1);
  assign last_lat = cnt_q == CNT_W'(MAC_LAT - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    taps_d = taps_q;
    sel_d = sel_q;
    case (state_q)
      S_IDLE: if (grant) begin
        state_d = S_GRANT;
        sel_d = win_idx;
        taps_d = req_taps_i[int'(win_idx)*TAP_W +: TAP_W];
      end
      S_GRANT: begin
        cnt_d = '0;
        state_d = taps_q != '0 ? S_RUN : post_run;
      end
      S_RUN: begin
        cnt_d = last_tap ? '0 : cnt_q + 1'b1;
        state_d = last_tap ? post_run : S_RUN;
      end
      S_DRAIN: begin
        cnt_d = last_lat ? '0 : cnt_q + 1'b1;
        state_d = last_lat ? S_DONE : S_DRAIN;
      end
      S_DONE: begin
        state_d = S_IDLE;
        sel_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      taps_q <= '0;
      sel_q <= '0;
      pend_q <= '0;
      ovr_q <= '0;
      done_q <= '0;
      idx_q <= '0;
      clr_q <= 1'b0;
      en_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      taps_q <= taps_d;
      sel_q <= sel_d;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
      done_q <= state_d == S_DONE ? N_REQ'(1) << sel_d : '0;
      idx_q <= state_d == S_RUN ? cnt_d[TAP_W-1:0] : '0;
      clr_q <= state_d == S_GRANT;
      en_q <= state_d == S_RUN;
      busy_q <= state_d != S_IDLE;
    end
  end
  assign mac_clr_o = clr_q;
  assign mac_en_o = en_q;
  assign mac_tap_idx_o = idx_q;
  assign mac_sel_o = sel_q;
  assign done_o = done_q;
  assign busy_o = busy_q;
  assign overrun_o = ovr_q;
endmodule

// File: tb/tb_decim_mac_scheduler.sv
// tb_decim_mac_scheduler: directed and random checks of the MAC scheduler against a job-timeline model
module tb_decim_mac_scheduler;
  localparam int TW = 5;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] req_i = '0;
  logic [3*TW-1:0] req_taps_i = '0;
  logic ovr_clr_i = 1'b0;
  logic mac_clr_o, mac_en_o, busy_o;
  logic [TW-1:0] mac_tap_idx_o;
  logic [1:0] mac_sel_o;
  logic [2:0] done_o, overrun_o;
  int checks = 0, failures = 0, cyc = 0, t0 = 0, en_cnt = 0;
  int dn[3];
  decim_mac_scheduler #(.N_REQ(3), .TAP_W(TW), .MAC_LAT(LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_i(req_i),
    .req_taps_i(req_taps_i),
    .ovr_clr_i(ovr_clr_i),
    .mac_clr_o(mac_clr_o),
    .mac_en_o(mac_en_o),
    .mac_tap_idx_o(mac_tap_idx_o),
    .mac_sel_o(mac_sel_o),
    .done_o(done_o),
    .busy_o(busy_o),
    .overrun_o(overrun_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask
  // Reference: a job is a timeline measured in cycles since its grant (phase 1 = clear,
  // phases 2..taps+1 = taps, done at taps+LAT+2, idle the cycle after).
  logic [2:0] m_pend = '0, m_ovr = '0, m_conf;
  logic m_act = 1'b0;
  int m_own = 0, m_taps = 0, m_ph = 0, m_ptr = 0, m_w;
  always_comb begin
    m_conf = m_pend;
    if (m_act) m_conf[m_own] = 1'b1;
    m_w = -1;
    if (!m_act)
      for (int k = 2; k >= 0; k--)
        if (m_pend[(m_ptr + k) % 3]) m_w = (m_ptr + k) % 3;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= '0;
      m_ovr <= '0;
      m_act <= 1'b0;
      m_own <= 0;
      m_taps <= 0;
      m_ph <= 0;
      m_ptr <= 0;
    end else begin
      m_ovr <= (ovr_clr_i ? 3'b000 : m_ovr) | (req_i & m_conf);
      m_pend <= (m_pend & ~(m_w >= 0 ? 3'(1 << m_w) : 3'b000)) | (req_i & ~m_conf);
      if (m_w >= 0) begin
        m_act <= 1'b1;
        m_own <= m_w;
        m_taps <= int'(req_taps_i[m_w*TW +: TW]);
        m_ph <= 1;
`ifdef DECIM_SCHED_RR_EN
        m_ptr <= (m_w + 1) % 3;
`endif
      end else if (m_act) begin
        m_ph <= m_ph + 1;
        if (m_ph == m_taps + LAT + 2) m_act <= 1'b0;
      end
    end
  end
  always @(negedge clk)
    if (rst_n) begin
      check("cyc_clr", 32'(mac_clr_o), 32'(m_act && m_ph == 1));
      check("cyc_en", 32'(mac_en_o), 32'(m_act && m_ph >= 2 && m_ph <= m_taps + 1));
      check("cyc_idx", 32'(mac_tap_idx_o), (m_act && m_ph >= 2 && m_ph <= m_taps + 1) ? m_ph - 2 : 0);
      check("cyc_done", 32'(done_o), (m_act && m_ph == m_taps + LAT + 2) ? 1 << m_own : 0);
      check("cyc_busy", 32'(busy_o), 32'(m_act));
      check("cyc_sel", 32'(mac_sel_o), m_act ? m_own : 0);
      check("cyc_ovr", 32'(overrun_o), 32'(m_ovr));
    end
  task automatic run_to(input int t);
    while (cyc < t) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) dn[i] += int'(done_o[i]);
      en_cnt += int'(mac_en_o);
    end
  endtask
  task automatic check_idle_outputs(input string p);
    check({p, "_busy"}, 32'(busy_o), 0);
    check({p, "_en"}, 32'(mac_en_o), 0);
    check({p, "_clr"}, 32'(mac_clr_o), 0);
    check({p, "_idx"}, 32'(mac_tap_idx_o), 0);
    check({p, "_sel"}, 32'(mac_sel_o), 0);
    check({p, "_done"}, 32'(done_o), 0);
    check({p, "_ovr"}, 32'(overrun_o), 0);
  endtask
  initial begin
    int nd;
    int ord[4];
    int dc[2];
    logic [2:0] rp;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    run_to(cyc + 3);
    // single FIR job, 26 taps
    req_taps_i = {5'd7, 5'd7, 5'd26};
    t0 = cyc;
    req_i = 3'b001;
    @(negedge clk) req_i = '0;
    run_to(t0 + 2);
    check("t1_clr", 32'(mac_clr_o), 1);
    run_to(t0 + 3);
    check("t1_en_first", 32'(mac_en_o), 1);
    check("t1_idx_first", 32'(mac_tap_idx_o), 0);
    run_to(t0 + 28);
    check("t1_idx_last", 32'(mac_tap_idx_o), 25);
    run_to(t0 + 29);
    check("t1_en_off", 32'(mac_en_o), 0);
    run_to(t0 + 30);
    check("t1_done_early", 32'(done_o), 0);
    run_to(t0 + 31);
    check("t1_done", 32'(done_o), 3'b001);
    run_to(t0 + 32);
    check("t1_busy_end", 32'(busy_o), 0);
    // all three at once, fixed priority order by default
    run_to(cyc + 3);
    t0 = cyc;
    req_i = 3'b111;
    @(negedge clk) req_i = '0;
    run_to(t0 + 20);
    check("t2_busy_a", 32'(busy_o), 1);
    run_to(t0 + 31);
    check("t2_done0", 32'(done_o), 3'b001);
    run_to(t0 + 40);
    check("t2_busy_b", 32'(busy_o), 1);
`ifndef DECIM_SCHED_RR_EN
    run_to(t0 + 43);
    check("t2_done1", 32'(done_o), 3'b010);
    run_to(t0 + 55);
    check("t2_done2", 32'(done_o), 3'b100);
`endif
    run_to(t0 + 60);
    // double request while pending -> overrun, one job only
    dn = '{0, 0, 0};
    t0 = cyc;
    req_i = 3'b010;
    @(negedge clk);
    @(negedge clk) req_i = '0;
    check("t3_ovr_set", 32'(overrun_o), 3'b010);
    run_to(t0 + 25);
    check("t3_one_done", dn[1], 1);
    ovr_clr_i = 1'b1;
    @(negedge clk) ovr_clr_i = 1'b0;
    check("t3_ovr_clr", 32'(overrun_o), 0);
    // zero taps skips RUN
    req_taps_i = {5'd0, 5'd7, 5'd26};
    en_cnt = 0;
    t0 = cyc;
    req_i = 3'b100;
    @(negedge clk) req_i = '0;
    run_to(t0 + 4);
    check("t4_done_early", 32'(done_o), 0);
    run_to(t0 + 5);
    check("t4_done", 32'(done_o), 3'b100);
    run_to(t0 + 10);
    check("t4_no_en", en_cnt, 0);
    // reset mid-RUN aborts the job
    t0 = cyc;
    req_i = 3'b001;
    @(negedge clk);
    @(negedge clk) req_i = '0;
    run_to(t0 + 10);
    check("t5_running", 32'(mac_en_o), 1);
    check("t5_ovr_before", 32'(overrun_o), 3'b001);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("t5_rst");
    @(negedge clk) rst_n = 1'b1;
    dn = '{0, 0, 0};
    run_to(cyc + 40);
    check("t5_no_done", dn[0], 0);
    check("t5_idle", 32'(busy_o), 0);
    // FIR and HB1 re-requesting after each done: neither is starved
    req_taps_i = {5'd0, 5'd3, 5'd3};
    nd = 0;
    dc = '{0, 0};
    ord = '{-1, -1, -1, -1};
    rp = '0;
    t0 = cyc;
    req_i = 3'b011;
    while (nd < 4 && cyc < t0 + 200) begin
      @(negedge clk);
      req_i = rp;
      rp = '0;
      for (int i = 0; i < 2; i++)
        if (done_o[i]) begin
          if (nd < 4) ord[nd] = i;
          nd++;
          dc[i]++;
          if (dc[i] < 2) rp[i] = 1'b1;
        end
    end
    req_i = '0;
    check("t6_timeout", nd, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t6_order%0d", i), ord[i], i % 2);
    run_to(cyc + 20);
    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int b = 0; b < 3; b++) begin
        req_i[b] = $urandom_range(0, 14) == 0;
        req_taps_i[b*TW +: TW] = $urandom_range(0, 5) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 8));
      end
      ovr_clr_i = $urandom_range(0, 15) == 0;
    end
    req_i = '0;
    ovr_clr_i = 1'b0;
    run_to(cyc + 150);
    check("end_idle", 32'(busy_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
